uart_word_sched: RTL and testbench
==================================

Name: uart_word_sched

Overview:
- Sequencing and arbitration controller placed in front of the byte-wide AXI4-Stream UART.
- Shares the UART transmitter between two 32-bit word requesters using round-robin arbitration, and serializes each granted word into 4 bytes, LSB first.
- On the receive side, assembles incoming UART bytes into 32-bit words with an inter-byte timeout that discards partial words.
- Sits between the processor/debug logic and the UART instance.

Parameters:
- DATA_WIDTH, 8, UART byte width; fixed at 8 for this block.
- WORD_BYTES, 4, bytes per word; fixed at 4, giving 32-bit words.
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of a partial RX word; must fit in 17 bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_data  in  32  word from requester 0.
- req0_valid  in  1  requester 0 has a word.
- req0_ready  out  1  one-cycle accept pulse to requester 0.
- req1_data  in  32  word from requester 1.
- req1_valid  in  1  requester 1 has a word.
- req1_ready  out  1  one-cycle accept pulse to requester 1.
- tx_tdata  out  8  byte to UART transmitter.
- tx_tvalid  out  1  byte valid.
- tx_tready  in  1  UART transmitter accepts byte.
- rx_tdata  in  8  byte from UART receiver.
- rx_tvalid  in  1  received byte valid.
- rx_tready  out  1  block accepts received byte.
- rx_word  out  32  assembled word.
- rx_word_valid  out  1  rx_word valid.
- rx_word_ready  in  1  consumer accepts rx_word.
- rx_timeout_err  out  1  one-cycle pulse when a partial word is discarded.
- grant  out  2  one-hot owner of the current TX word; 00 when idle.
- tx_word_busy  out  1  a TX word is in progress.
- rx_word_count  out  16  count of completed RX words; wraps.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0; rx_tready goes to 1 on the first cycle after reset.
  - TX FSM goes to IDLE and RX assembly is cleared.
  - last_grant is set to 1, so requester 0 wins first.
  - Reset asserted mid-word aborts the word; remaining bytes are not sent, and nothing is replayed after reset.
- TX FSM, states IDLE and SEND:
  - IDLE, with any reqN_valid:
    - Pick the winner. With both valid, grant the requester other than last_grant; with one valid, grant that one.
    - In the same cycle, assert the winner's reqN_ready (combinational, single cycle). Latch its data, set grant, set byte_idx=0, update last_grant, go to SEND.
  - SEND:
    - tx_tvalid=1 and tx_tdata=word[8*byte_idx +: 8]; tx_word_busy=1.
    - On tx_tvalid&&tx_tready: byte_idx++. If byte_idx was 3, go to IDLE with grant=00 and tx_tvalid deasserted in the next cycle.
    - tx_tdata is stable while tx_tvalid is high and tx_tready is low.
  - Latency: accept cycle to first tx_tvalid is 1 clock. Minimum word time is 5 clocks (accept plus 4 bytes with tready always high).
  - A new arbitration happens only in IDLE; a word is never interleaved with another.
  - reqN_ready is never asserted while in SEND.
- RX assembler:
  - rx_tready = !(rx_word_valid && !rx_word_ready).
  - On rx_tvalid&&rx_tready: store the byte at position rx_idx (LSB first), rx_idx++, clear the timeout counter.
  - On the 4th byte: rx_word and rx_word_valid=1 appear the next cycle, rx_idx=0, and rx_word_count increments (wraps 0xFFFF to 0).
  - rx_word_valid holds until rx_word_ready.
  - Simultaneous rx_word_ready and new byte: the byte is accepted (rx_tready=1 that cycle). Words can be consumed back-to-back.
  - A 4th byte completing while the previous word is still pending cannot occur, because rx_tready=0 in that case.
- Timeout:
  - When rx_idx is 1..3 and no byte arrives, the counter increments each clock.
  - When it reaches TIMEOUT_CYCLES-1: clear rx_idx and the partial data, pulse rx_timeout_err for 1 clock, and reset the counter.
  - The counter is held at 0 when rx_idx=0.
  - A byte arriving in the same cycle as the timeout wins: it is taken as byte rx_idx, and no error is raised.
- TX and RX paths are fully independent.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst=0 for 3 clocks, release.
  - Required: all outputs 0 except rx_tready=1; grant=00.
- Single word:
  - Stimulus: req0_data=0xA1B2C3D4, req0_valid for 1 cycle, tx_tready=1.
  - Required: req0_ready pulses once; tx_tdata sequence D4,C3,B2,A1 on 4 consecutive clocks; grant=01 during SEND; tx_word_busy falls after the 4th byte.
- Contention and round-robin:
  - Stimulus: both requesters valid continuously, req0=0x11111111, req1=0x22222222.
  - Required: granted words alternate req0, req1, req0, req1.
- Back-pressure:
  - Stimulus: tx_tready low for 10 clocks during byte 2.
  - Required: tx_tdata holds 0xB2 with tvalid high; no byte skipped or duplicated; total of 4 handshakes.
- RX assembly and stall:
  - Stimulus: bytes 0x78,0x56,0x34,0x12 with rx_word_ready=0, then 4 more bytes.
  - Required: rx_word=0x12345678 and rx_word_valid=1; rx_tready=0 only once the 4-byte word is complete and unconsumed; rx_word_count=1; after rx_word_ready, the next word assembles correctly.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50; send 2 bytes, then go idle for 60 clocks, then send 4 bytes 0x01..0x04.
  - Required: one rx_timeout_err pulse 50 clocks after the 2nd byte; the next word is 0x04030201; rx_word_count advances by 1 only.

Source files
------------

// File: rtl/uart_word_sched.sv
// Round-robin TX word scheduler and RX word assembler for a byte-wide AXI4-Stream UART.
// TX words go out LSB first; RX partial words are dropped after an inter-byte idle timeout.
module uart_word_sched #(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*WORD_BYTES-1:0] req0_data,
  input  logic                             req0_valid,
  output logic                             req0_ready,
  input  logic [DATA_WIDTH*WORD_BYTES-1:0] req1_data,
  input  logic                             req1_valid,
  output logic                             req1_ready,
  output logic [DATA_WIDTH-1:0]            tx_tdata,
  output logic                             tx_tvalid,
  input  logic                             tx_tready,
  input  logic [DATA_WIDTH-1:0]            rx_tdata,
  input  logic                             rx_tvalid,
  output logic                             rx_tready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] rx_word,
  output logic                             rx_word_valid,
  input  logic                             rx_word_ready,
  output logic                             rx_timeout_err,
  output logic [1:0]                       grant,
  output logic                             tx_word_busy,
  output logic [15:0]                      rx_word_count
);

  localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
  localparam int IDX_W  = $clog2(WORD_BYTES);
  localparam int TMO_W  = 17;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  tx_state_e          state_q, state_d;
  logic [WORD_W-1:0]  txw_q, txw_d;
  logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
  logic [1:0]         grant_q, grant_d;
  logic               last_q, last_d;
  logic               win0, win1;

  // last_q=1 means requester 1 held the most recent grant, so requester 0 wins a tie
  assign win0 = req0_valid && (!req1_valid || last_q);
  assign win1 = req1_valid && (!req0_valid || !last_q);

  assign tx_tdata = txw_q[tx_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant    = grant_q;

  always_comb begin
    state_d      = state_q;
    txw_d        = txw_q;
    tx_idx_d     = tx_idx_q;
    grant_d      = grant_q;
    last_d       = last_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    tx_tvalid    = 1'b0;
    tx_word_busy = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (rst && (win0 || win1)) begin
          req0_ready = win0;
          req1_ready = win1;
          txw_d      = win0 ? req0_data : req1_data;
          grant_d    = {win1, win0};
          last_d     = win1;
          tx_idx_d   = '0;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_tvalid    = 1'b1;
        tx_word_busy = 1'b1;
        if (tx_tready) begin
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == IDX_LAST) begin
            state_d = TX_IDLE;
            grant_d = 2'b00;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= TX_IDLE;
      txw_q    <= '0;
      tx_idx_q <= '0;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      txw_q    <= txw_d;
      tx_idx_q <= tx_idx_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  logic [WORD_W-1:0] part_q, part_d;
  logic [WORD_W-1:0] rxw_q, rxw_d;
  logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
  logic              rx_vld_q, rx_vld_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              rx_acc;

  // A completed word can only stall input while nobody is taking it
  assign rx_tready      = !(rx_vld_q && !rx_word_ready);
  assign rx_acc         = rx_tvalid && rx_tready;
  assign rx_word        = rxw_q;
  assign rx_word_valid  = rx_vld_q;
  assign rx_word_count  = cnt_q;
  assign rx_timeout_err = err_q;

  always_comb begin
    part_d   = part_q;
    rxw_d    = rxw_q;
    rx_idx_d = rx_idx_q;
    rx_vld_d = rx_vld_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    err_d    = 1'b0;
    if (rx_vld_q && rx_word_ready) rx_vld_d = 1'b0;
    if (rx_acc) begin
      part_d[rx_idx_q*DATA_WIDTH +: DATA_WIDTH] = rx_tdata;
      tmo_d = '0;
      if (rx_idx_q == IDX_LAST) begin
        rxw_d    = part_d;
        rx_vld_d = 1'b1;
        rx_idx_d = '0;
        part_d   = '0;
        cnt_d    = cnt_q + 16'd1;
      end else begin
        rx_idx_d = rx_idx_q + 1'b1;
      end
    end else if (rx_idx_q != '0) begin
      // An arriving byte takes priority, so the timeout only fires on an idle cycle
      if (tmo_q == TMO_LAST) begin
        rx_idx_d = '0;
        part_d   = '0;
        err_d    = 1'b1;
        tmo_d    = '0;
      end else begin
        tmo_d = tmo_q + 17'd1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      part_q   <= '0;
      rxw_q    <= '0;
      rx_idx_q <= '0;
      rx_vld_q <= 1'b0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      part_q   <= part_d;
      rxw_q    <= rxw_d;
      rx_idx_q <= rx_idx_d;
      rx_vld_q <= rx_vld_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_word_sched.sv
// Bench for uart_word_sched: a word-level model checked every cycle, plus directed literal checks.
module tb_uart_word_sched;
  localparam int TO = 50;

  logic        clk = 1'b0, rst = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid, tx_tready = 1'b0;
  logic [7:0]  rx_tdata = '0;
  logic        rx_tvalid = 1'b0, rx_tready;
  logic [31:0] rx_word;
  logic        rx_word_valid, rx_word_ready = 1'b0, rx_timeout_err;
  logic [1:0]  grant;
  logic        tx_word_busy;
  logic [15:0] rx_word_count;

  uart_word_sched #(.DATA_WIDTH(8), .WORD_BYTES(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid), .rx_word_ready(rx_word_ready),
    .rx_timeout_err(rx_timeout_err), .grant(grant), .tx_word_busy(tx_word_busy),
    .rx_word_count(rx_word_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, cyc = 0;
  int err_cnt = 0, err_cyc = 0, acc_cyc = 0;
  int tx_log[$];
  int g_log[$];

  // Model: TX as "word in flight + bytes already sent", RX as a byte queue plus a pending word
  bit          m_busy = 0, m_pend = 0, m_err = 0;
  logic [31:0] m_word = '0, m_pword = '0;
  int          m_sent = 0, m_owner = 0, m_last = 1, m_idle = 0, m_cnt = 0;
  logic [7:0]  m_bytes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) cyc++;

  // Inputs only change just after a rising edge, so at the falling edge they equal what
  // the next rising edge will sample: compare first, then advance the model.
  always @(negedge clk) begin : cmp_and_step
    int w;
    bit rdy;
    w   = winner();
    rdy = !(m_pend && !rx_word_ready);
    if (rst) begin
      chk("req0_ready", 32'(req0_ready), 32'(!m_busy && w == 0));
      chk("req1_ready", 32'(req1_ready), 32'(!m_busy && w == 1));
      chk("tx_tvalid", 32'(tx_tvalid), 32'(m_busy));
      chk("tx_word_busy", 32'(tx_word_busy), 32'(m_busy));
      chk("grant", 32'(grant), m_busy ? (m_owner == 0 ? 32'd1 : 32'd2) : 32'd0);
      if (m_busy) chk("tx_tdata", 32'(tx_tdata), 32'(8'(m_word >> (8 * m_sent))));
      chk("rx_tready", 32'(rx_tready), 32'(rdy));
      chk("rx_word_valid", 32'(rx_word_valid), 32'(m_pend));
      if (m_pend) chk("rx_word", rx_word, m_pword);
      chk("rx_word_count", 32'(rx_word_count), 32'(m_cnt));
      chk("rx_timeout_err", 32'(rx_timeout_err), 32'(m_err));
      if (tx_tvalid && tx_tready) tx_log.push_back(int'(tx_tdata));
      if (req0_ready) g_log.push_back(0);
      if (req1_ready) g_log.push_back(1);
      if (rx_timeout_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
    if (!rst) begin
      m_busy = 0; m_last = 1; m_sent = 0; m_bytes.delete();
      m_idle = 0; m_pend = 0; m_cnt = 0; m_err = 0; m_pword = '0;
    end else begin
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy = 1; m_word = (w == 1) ? req1_data : req0_data;
          m_sent = 0; m_owner = w; m_last = w;
        end
      end else if (tx_tready) begin
        m_sent++;
        if (m_sent == 4) m_busy = 0;
      end
      m_err = 0;
      if (m_pend && rx_word_ready) m_pend = 0;
      if (rx_tvalid && rdy) begin
        m_bytes.push_back(rx_tdata);
        m_idle = 0;
        if (m_bytes.size() == 4) begin
          m_pword = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_pend  = 1;
          m_cnt   = (m_cnt + 1) % 65536;
          m_bytes.delete();
        end
      end else if (m_bytes.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          m_bytes.delete();
          m_idle = 0;
          m_err  = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b);
    bit ok;
    ok = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      at_neg();
      if (rx_tready) begin
        ok = 1;
        acc_cyc = cyc;
      end
      tick();
    end
    rx_tvalid = 1'b0;
    chk("rx_handshake", 32'(ok), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] exp1[4];
    int         rr[4];
    exp1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    rr   = '{0, 1, 0, 1};

    repeat (3) tick();
    rst = 1'b1;
    at_neg();
    chk("rst_tx_tvalid", 32'(tx_tvalid), 32'd0);
    chk("rst_busy", 32'(tx_word_busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_tdata", 32'(tx_tdata), 32'd0);
    chk("rst_rx_tready", 32'(rx_tready), 32'd1);
    chk("rst_rx_valid", 32'(rx_word_valid), 32'd0);
    chk("rst_rx_word", rx_word, 32'd0);
    chk("rst_count", 32'(rx_word_count), 32'd0);
    chk("rst_err", 32'(rx_timeout_err), 32'd0);
    tick();

    // Single word, no back-pressure
    tx_tready = 1'b1; req0_data = 32'hA1B2C3D4; req0_valid = 1'b1;
    at_neg();
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    at_neg();
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_busy", 32'(tx_word_busy), 32'd1);
    chk("t1_byte0", 32'(tx_tdata), 32'hD4);
    repeat (4) tick();
    at_neg();
    chk("t1_busy_fall", 32'(tx_word_busy), 32'd0);
    chk("t1_nbytes", 32'(tx_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++) chk("t1_seq", 32'(tx_log[i]), 32'(exp1[i]));
    chk("t1_ngrants", 32'(g_log.size()), 32'd1);
    tick();

    // Contention: after reset requester 0 wins first, then strict alternation
    pulse_reset();
    tx_log.delete(); g_log.delete();
    req0_data = 32'h11111111; req1_data = 32'h22222222;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (20) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) tick();
    chk("rr_ngrants", 32'(g_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < g_log.size(); i++) chk("rr_order", 32'(g_log[i]), 32'(rr[i]));
    chk("rr_nbytes", 32'(tx_log.size()), 32'd16);
    if (tx_log.size() == 16) begin
      chk("rr_byte0", 32'(tx_log[0]), 32'h11);
      chk("rr_byte4", 32'(tx_log[4]), 32'h22);
      chk("rr_byte15", 32'(tx_log[15]), 32'h22);
    end

    // Back-pressure on byte 2
    tx_log.delete(); g_log.delete();
    req0_data = 32'hA1B2C3D4; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tx_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      chk("bp_tvalid", 32'(tx_tvalid), 32'd1);
      chk("bp_hold", 32'(tx_tdata), 32'hB2);
      tick();
    end
    tx_tready = 1'b1;
    repeat (4) tick();
    chk("bp_nbytes", 32'(tx_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++) chk("bp_seq", 32'(tx_log[i]), 32'(exp1[i]));

    // RX assembly with a stalled consumer
    rx_word_ready = 1'b0;
    rx_send(8'h78); rx_send(8'h56); rx_send(8'h34); rx_send(8'h12);
    at_neg();
    chk("rx_word1", rx_word, 32'h12345678);
    chk("rx_valid1", 32'(rx_word_valid), 32'd1);
    chk("rx_stall", 32'(rx_tready), 32'd0);
    chk("rx_count1", 32'(rx_word_count), 32'd1);
    tick();
    rx_tdata = 8'hEF; rx_tvalid = 1'b1;
    tick();
    tick();
    rx_word_ready = 1'b1;
    at_neg();
    chk("rx_concurrent", 32'(rx_tready), 32'd1);
    tick();
    rx_word_ready = 1'b0; rx_tvalid = 1'b0;
    rx_send(8'hCD); rx_send(8'hAB); rx_send(8'h89);
    at_neg();
    chk("rx_word2", rx_word, 32'h89ABCDEF);
    chk("rx_count2", 32'(rx_word_count), 32'd2);
    tick();
    rx_word_ready = 1'b1;
    tick();
    rx_word_ready = 1'b0;

    // Timeout of a 2-byte partial word, then a clean word
    err_cnt = 0;
    rx_send(8'hAA); rx_send(8'hBB);
    repeat (60) tick();
    at_neg();
    chk("tmo_pulses", 32'(err_cnt), 32'd1);
    // The byte is taken at the edge closing cycle acc_cyc; the error follows TO edges later
    chk("tmo_delay", 32'(err_cyc - acc_cyc - 1), 32'(TO));
    tick();
    rx_send(8'h01); rx_send(8'h02); rx_send(8'h03); rx_send(8'h04);
    at_neg();
    chk("tmo_word", rx_word, 32'h04030201);
    chk("tmo_count", 32'(rx_word_count), 32'd3);
    tick();
    rx_word_ready = 1'b1;
    tick();
    rx_word_ready = 1'b0;

    // A byte landing on the expiry cycle wins over the timeout
    rx_send(8'h55);
    repeat (TO - 1) tick();
    rx_send(8'h66); rx_send(8'h77); rx_send(8'h88);
    at_neg();
    chk("edge_no_err", 32'(err_cnt), 32'd1);
    chk("edge_word", rx_word, 32'h88776655);
    chk("edge_count", 32'(rx_word_count), 32'd4);
    tick();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
